cen_mean_estimator: RTL and testbench

Per-channel mean estimator for the 4-channel centering stage of the whitening path. Accumulates N = 2^LOG2N unsigned samples on each of four channels, then produces the floor of each channel's mean. The results drive the `res1`..`res4` mean inputs of the centering subtractor, which forms `x - mean`. Results are held stable until the next estimation completes, so centering runs undisturbed while a new mean is being gathered.

---
 rtl/cen_mean_estimator.sv | 135 +++++++++++++
 tb/tb_cen_mean_estimator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cen_mean_estimator.sv
// -----------------------------------------------------------------------------
// cen_mean_estimator
//
// Per-channel mean estimator for the 4-channel centering stage. After a GO
// pulse it sums N = 2^LOG2N qualified samples on each channel. It then writes
// floor(sum / N) to res1..res4. The results stay unchanged until the next run
// completes, so the downstream subtractor can keep using the old means while a
// new set is being gathered.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   GO             start pulse, accepted only in IDLE or HOLD
//   En             sample-valid qualifier for x1_in..x4_in
//   x1_in..x4_in   unsigned channel samples, W bits
//   res1..res4     registered unsigned channel means, W bits
//   busy           high while accumulating or dividing
//   valid          high while res* holds the means of a completed run
//   done           one-cycle pulse when new means are written
// -----------------------------------------------------------------------------
module cen_mean_estimator #(
  parameter int W     = 26,
  parameter int LOG2N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         GO,
  input  logic         En,
  input  logic [W-1:0] x1_in,
  input  logic [W-1:0] x2_in,
  input  logic [W-1:0] x3_in,
  input  logic [W-1:0] x4_in,
  output logic [W-1:0] res1,
  output logic [W-1:0] res2,
  output logic [W-1:0] res3,
  output logic [W-1:0] res4,
  output logic         busy,
  output logic         valid,
  output logic         done
);

  // The accumulators are LOG2N bits wider than a sample. This gives room for
  // N full-scale samples without overflow.
  localparam int AW = W + LOG2N;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, HOLD} state_t;

  state_t         state;
  state_t         next_state;
  logic [W-1:0]   x_vec [4];
  logic [AW-1:0]  acc   [4];
  logic [W-1:0]   res_q [4];
  logic [LOG2N-1:0] cnt;
  logic           start;
  logic           take;
  logic           last;

  assign x_vec[0] = x1_in;
  assign x_vec[1] = x2_in;
  assign x_vec[2] = x3_in;
  assign x_vec[3] = x4_in;

  assign res1 = res_q[0];
  assign res2 = res_q[1];
  assign res3 = res_q[2];
  assign res4 = res_q[3];

  assign start = ((state == IDLE) || (state == HOLD)) && GO;
  assign take  = (state == ACCUM) && En;
  // The counter reads N-1 (all ones) while the N-th sample is being taken.
  assign last  = take && (&cnt);

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples its inputs as they stood before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case statement. As a result,
  // every path through the block assigns it, and synthesis does not infer a
  // latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, HOLD: if (GO)   next_state = ACCUM;
      ACCUM:      if (last) next_state = DIV;
      DIV:                  next_state = HOLD;
      default:              next_state = IDLE;
    endcase
  end

  // NOTE: the small accumulator and result arrays are flops, not a RAM. They
  // are therefore reset explicitly, so a reset in the middle of a run throws
  // away the partial sums and leaves the outputs at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        acc[k]   <= '0;
        res_q[k] <= '0;
      end
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (start) begin
        for (int k = 0; k < 4; k++) acc[k] <= '0;
        cnt <= '0;
      end else if (take) begin
        for (int k = 0; k < 4; k++) acc[k] <= acc[k] + AW'(x_vec[k]);
        // Hold the count at N-1 on the final sample so it never wraps in a run.
        if (!last) cnt <= cnt + LOG2N'(1);
      end

      // Dropping the low LOG2N bits is the floor of sum / N.
      if (state == DIV) begin
        for (int k = 0; k < 4; k++) res_q[k] <= acc[k][AW-1:LOG2N];
      end

      if (start) begin
        valid <= 1'b0;
      end else if (state == DIV) begin
        valid <= 1'b1;
      end

      done <= (state == DIV);
      busy <= (next_state == ACCUM) || (next_state == DIV);
    end
  end

endmodule

// File: tb/tb_cen_mean_estimator.sv
// -----------------------------------------------------------------------------
// tb_cen_mean_estimator
//
// Directed and randomized bench for cen_mean_estimator with W = 26, N = 4.
// The reference keeps running per-channel sums of the qualified samples. The
// expected mean of each channel is the integer quotient sum / N.
// -----------------------------------------------------------------------------
module tb_cen_mean_estimator;

  localparam int W     = 26;
  localparam int LOG2N = 2;
  localparam int N     = 4;
  localparam logic [W-1:0] FULL = '1;

  logic         clk;
  logic         rst_n;
  logic         GO;
  logic         En;
  logic [W-1:0] xs    [4];
  logic [W-1:0] res_o [4];
  logic         busy;
  logic         valid;
  logic         done;

  int tests = 0;
  int fails = 0;

  // Reference model state
  longint       sum_m   [4];
  int           n_m;
  logic [W-1:0] exp_res [4];

  cen_mean_estimator #(.W(W), .LOG2N(LOG2N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .GO    (GO),
    .En    (En),
    .x1_in (xs[0]),
    .x2_in (xs[1]),
    .x3_in (xs[2]),
    .x4_in (xs[3]),
    .res1  (res_o[0]),
    .res2  (res_o[1]),
    .res3  (res_o[2]),
    .res4  (res_o[3]),
    .busy  (busy),
    .valid (valid),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_res%0d", tag, k + 1), res_o[k], exp_res[k]);
  endtask

  function automatic logic [W-1:0] rnd_sample();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 3) == 0) v = FULL;
    return v;
  endfunction

  task automatic rnd_inputs();
    for (int k = 0; k < 4; k++) xs[k] = rnd_sample();
  endtask

  // Pulse GO. Inputs in the GO cycle carry random data and a random En; the
  // design must not accumulate them.
  task automatic start_run(input string tag);
    GO = 1'b1;
    En = 1'($urandom);
    rnd_inputs();
    @(negedge clk);
    GO = 1'b0;
    En = 1'b0;
    for (int k = 0; k < 4; k++) sum_m[k] = 0;
    n_m = 0;
    check({tag, "_busy"},  busy,  1'b1);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_done"},  done,  1'b0);
    check_res({tag, "_hold"});
  endtask

  // Present `gap` unqualified cycles, then one qualified sample.
  task automatic feed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      En = 1'b0;
      rnd_inputs();
      @(negedge clk);
      check({tag, "_gap_done"},  done,  1'b0);
      check({tag, "_gap_valid"}, valid, 1'b0);
      check({tag, "_gap_busy"},  busy,  1'b1);
    end
    xs[0] = a; xs[1] = b; xs[2] = c; xs[3] = d;
    En = 1'b1;
    @(negedge clk);
    En = 1'b0;
    sum_m[0] += a; sum_m[1] += b; sum_m[2] += c; sum_m[3] += d;
    n_m++;
  endtask

  // Called at the negedge after the N-th sample, when the design sits in DIV.
  task automatic finish_run(input string tag, input bit go_in_div);
    check({tag, "_div_done"}, done, 1'b0);
    check({tag, "_div_busy"}, busy, 1'b1);
    check({tag, "_nsamples"}, 64'(n_m), 64'(N));
    for (int k = 0; k < 4; k++) exp_res[k] = W'(sum_m[k] / N);
    if (go_in_div) GO = 1'b1;
    @(negedge clk);
    GO = 1'b0;
    check({tag, "_done"},  done,  1'b1);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_busy"},  busy,  1'b0);
    check_res(tag);
  endtask

  // HOLD: results stay stable and En is ignored.
  task automatic hold_cycles(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      En = 1'b1;
      rnd_inputs();
      @(negedge clk);
      check({tag, "_done"},  done,  1'b0);
      check({tag, "_valid"}, valid, 1'b1);
      check({tag, "_busy"},  busy,  1'b0);
      check_res(tag);
    end
    En = 1'b0;
  endtask

  initial begin
    GO = 1'b0;
    En = 1'b0;
    for (int k = 0; k < 4; k++) begin
      xs[k]      = '0;
      exp_res[k] = '0;
      sum_m[k]   = 0;
    end
    n_m   = 0;
    rst_n = 1'b0;

    // Reset state
    #1;
    check("rst_busy",  busy,  1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_done",  done,  1'b0);
    check_res("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores En
    En = 1'b1;
    rnd_inputs();
    @(negedge clk);
    En = 1'b0;
    check("idle_busy",  busy,  1'b0);
    check("idle_valid", valid, 1'b0);
    check_res("idle");

    // Constant input
    start_run("const_go");
    for (int i = 0; i < N; i++) feed("const", 26'd100, 26'd0, 26'd7, 26'd3, 0);
    finish_run("const", 1'b0);
    hold_cycles("const_hold", 2);

    // Floor rounding with En gaps on channel 2
    start_run("floor_go");
    for (int i = 0; i < N; i++)
      feed("floor", rnd_sample(), W'(i + 1), rnd_sample(), rnd_sample(), 2);
    finish_run("floor", 1'b0);
    check("floor_res2_value", res_o[1], 26'd2);

    // Full scale, with GO during DIV (must be ignored)
    start_run("full_go");
    for (int i = 0; i < N; i++) feed("full", FULL, FULL, FULL, FULL, 0);
    finish_run("full", 1'b1);
    for (int k = 0; k < 4; k++) check($sformatf("full_value%0d", k + 1), res_o[k], FULL);
    hold_cycles("full_hold", 1);

    // GO while busy is ignored
    start_run("gobusy_go");
    for (int i = 0; i < 2; i++) feed("gobusy", rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 0);
    GO = 1'b1;
    @(negedge clk);
    GO = 1'b0;
    check("gobusy_mid_busy",  busy,  1'b1);
    check("gobusy_mid_valid", valid, 1'b0);
    for (int i = 0; i < 2; i++) feed("gobusy", rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 1);
    finish_run("gobusy", 1'b0);

    // Hold across restart; the second GO lands in the done cycle
    start_run("restart1_go");
    for (int i = 0; i < N; i++) feed("restart1", 26'd100, rnd_sample(), rnd_sample(), rnd_sample(), 0);
    finish_run("restart1", 1'b0);
    check("restart1_res1_value", res_o[0], 26'd100);
    start_run("restart2_go");
    for (int i = 0; i < N; i++) begin
      feed("restart2", 26'd20, rnd_sample(), rnd_sample(), rnd_sample(), 1);
      if (i < N - 1) begin
        check("restart2_acc_res1",  res_o[0], 26'd100);
        check("restart2_acc_valid", valid,    1'b0);
      end
    end
    finish_run("restart2", 1'b0);
    check("restart2_res1_value", res_o[0], 26'd20);

    // Reset mid-run
    start_run("midrst_go");
    for (int i = 0; i < 3; i++) feed("midrst", rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) exp_res[k] = '0;
    check("midrst_busy",  busy,  1'b0);
    check("midrst_valid", valid, 1'b0);
    check("midrst_done",  done,  1'b0);
    check_res("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    En = 1'b1;
    rnd_inputs();
    @(negedge clk);
    En = 1'b0;
    check("midrst_idle_busy", busy, 1'b0);
    check_res("midrst_idle");
    start_run("fresh_go");
    for (int i = 0; i < N; i++) feed("fresh", rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 0);
    finish_run("fresh", 1'b0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      start_run($sformatf("rnd%0d_go", r));
      for (int i = 0; i < N; i++)
        feed($sformatf("rnd%0d", r), rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(),
             int'($urandom_range(0, 2)));
      finish_run($sformatf("rnd%0d", r), 1'($urandom));
      hold_cycles($sformatf("rnd%0d_hold", r), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
